rr_output_port_allocator: RTL and testbench

//   Round-robin, packet-locking allocator for one router output port with downstream credit tracking.

---
 rtl/rr_output_port_allocator_if.sv | 27 ++
 rtl/rr_output_port_allocator.sv | 135 +++++++++++++
 tb/tb_rr_output_port_allocator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_output_port_allocator_if.sv
// Request/grant/credit bundle between input-buffer read logic and one output-port allocator.
// master: input-port side driving requests and transfer strobes; slave: the allocator.
interface rr_output_port_allocator_if #(
   parameter int N      = 5,
   parameter int IDX_W  = 3,
   parameter int CRED_W = 3
);
   logic [N-1:0]      req;
   logic              flit_sent;
   logic              tail_sent;
   logic              credit_in;
   logic [N-1:0]      gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic              send_ok;
   logic [CRED_W-1:0] credits;
   logic              stall_err;

   modport master (
      output req, flit_sent, tail_sent, credit_in,
      input  gnt, gnt_idx, send_ok, credits, stall_err
   );

   modport slave (
      input  req, flit_sent, tail_sent, credit_in,
      output gnt, gnt_idx, send_ok, credits, stall_err
   );
endinterface

// File: rtl/rr_output_port_allocator.sv
// Round-robin packet-locking allocator for one router output port with downstream credit tracking.
// Optional stall watchdog enabled by defining ARB_STALL_WDOG_EN.
module rr_output_port_allocator #(
   parameter int N        = 5,
   parameter int IDX_W    = 3,
   parameter int CREDITS  = 4,
   parameter int CRED_W   = 3,
   parameter int MAX_HOLD = 16
) (
   input logic clk,
   input logic rst,
   rr_output_port_allocator_if.slave port
);

   typedef enum logic {IDLE, LOCK} state_t;

   if ((1 << IDX_W) < N || CREDITS >= (1 << CRED_W) || CREDITS < 1 || MAX_HOLD < 1) begin : g_param_chk
      $error("rr_output_port_allocator: inconsistent parameters");
   end

   state_t            state, state_nxt;
   logic [N-1:0]      gnt_r, gnt_nxt;
   logic [IDX_W-1:0]  idx_r, idx_nxt;
   logic [IDX_W-1:0]  ptr, ptr_nxt;
   logic [CRED_W-1:0] cred_r, cred_nxt;
   logic              pick_vld;
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W-1:0]  cand;
   logic              send_ok;
   logic              xfer;
   logic              release_lock;

   assign send_ok      = (state == LOCK) && (cred_r != '0);
   assign xfer         = port.flit_sent && send_ok;
   assign release_lock = (xfer && port.tail_sent) || !port.req[idx_r];

   // Rotating-priority scan: first requester at or after ptr, wrapping mod N.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 0; k < N; k++) begin
         cand = IDX_W'((int'(ptr) + k) % N);
         if (!pick_vld && port.req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_r;
      idx_nxt   = idx_r;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt         = LOCK;
               gnt_nxt           = '0;
               gnt_nxt[pick_idx] = 1'b1;
               idx_nxt           = pick_idx;
            end
         end
         LOCK: begin
            if (release_lock) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               ptr_nxt   = (idx_r == IDX_W'(N - 1)) ? '0 : idx_r + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Simultaneous send and return cancel; returns beyond CREDITS are dropped.
   always_comb begin
      cred_nxt = cred_r;
      if (xfer && !port.credit_in)
         cred_nxt = cred_r - 1'b1;
      else if (port.credit_in && !xfer && cred_r != CRED_W'(CREDITS))
         cred_nxt = cred_r + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         gnt_r  <= '0;
         idx_r  <= '0;
         ptr    <= '0;
         cred_r <= CRED_W'(CREDITS);
      end else begin
         state  <= state_nxt;
         gnt_r  <= gnt_nxt;
         idx_r  <= idx_nxt;
         ptr    <= ptr_nxt;
         cred_r <= cred_nxt;
      end
   end

   assign port.gnt     = gnt_r;
   assign port.gnt_idx = idx_r;
   assign port.send_ok = send_ok;
   assign port.credits = cred_r;

`ifdef ARB_STALL_WDOG_EN
   localparam int WD_W = $clog2(MAX_HOLD + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            stall_r;
   logic            stall_cond;

   assign stall_cond = (state == LOCK) && (cred_r == '0);

   // Flag rises on the edge where the count reaches MAX_HOLD; the lock itself is left alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt  <= '0;
         stall_r <= 1'b0;
      end else if (!stall_cond) begin
         wd_cnt <= '0;
      end else begin
         if (wd_cnt != WD_W'(MAX_HOLD))
            wd_cnt <= wd_cnt + 1'b1;
         if (wd_cnt == WD_W'(MAX_HOLD - 1))
            stall_r <= 1'b1;
      end
   end

   assign port.stall_err = stall_r;
`else
   assign port.stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_output_port_allocator.sv
// Randomized and directed bench for rr_output_port_allocator against a packet-level reference model.
// Watchdog expectations follow ARB_STALL_WDOG_EN.
module tb_rr_output_port_allocator;

   localparam int N        = 5;
   localparam int IDX_W    = 3;
   localparam int CREDITS  = 4;
   localparam int CRED_W   = 3;
   localparam int MAX_HOLD = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rr_output_port_allocator_if #(.N(N), .IDX_W(IDX_W), .CRED_W(CRED_W)) bus ();

   rr_output_port_allocator #(
      .N(N), .IDX_W(IDX_W), .CREDITS(CREDITS), .CRED_W(CRED_W), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .port(bus)
   );

   // Reference model: who owns the port, where the rotation resumes, how many slots are free.
   bit m_lock;
   int m_own, m_idx, m_ptr, m_cred, m_wd;
   bit m_stall;

   int n_vec = 0;
   int n_err = 0;
   int order[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lock  = 1'b0;
      m_own   = 0;
      m_idx   = 0;
      m_ptr   = 0;
      m_cred  = CREDITS;
      m_wd    = 0;
      m_stall = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input bit f, input bit t, input bit c);
      bit ok, v, found;
      ok = m_lock && (m_cred > 0);
      v  = f && ok;
      if (m_lock && m_cred == 0) begin
         if (m_wd < MAX_HOLD) m_wd++;
         if (m_wd == MAX_HOLD) m_stall = 1'b1;
      end else begin
         m_wd = 0;
      end
      if (v && !c) m_cred--;
      else if (c && !v && m_cred < CREDITS) m_cred++;
      if (!m_lock) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!found && r[(m_ptr + k) % N]) begin
               found  = 1'b1;
               m_own  = (m_ptr + k) % N;
               m_idx  = m_own;
               m_lock = 1'b1;
            end
         end
      end else if ((v && t) || !r[m_own]) begin
         m_lock = 1'b0;
         m_ptr  = (m_own + 1) % N;
      end
   endtask

   task automatic step(input logic [N-1:0] r, input bit f, input bit t, input bit c, input bit rs);
      logic [N-1:0] exp_gnt;
      bus.req       = r;
      bus.flit_sent = f;
      bus.tail_sent = t;
      bus.credit_in = c;
      rst           = rs;
      if (rs) model_reset();
      else    model_step(r, f, t, c);
      @(posedge clk);
      #1;
      exp_gnt = '0;
      if (m_lock) exp_gnt[m_own] = 1'b1;
      chk("gnt",     32'(bus.gnt),     32'(exp_gnt));
      chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
      chk("send_ok", 32'(bus.send_ok), 32'(m_lock && m_cred != 0));
      chk("credits", 32'(bus.credits), 32'(m_cred));
`ifdef ARB_STALL_WDOG_EN
      chk("stall_err", 32'(bus.stall_err), 32'(m_stall));
`else
      chk("stall_err", 32'(bus.stall_err), 32'd0);
`endif
   endtask

   initial begin
      logic [N-1:0] r;
      bit f, t, c, rs;
      model_reset();
      bus.req = '0; bus.flit_sent = 1'b0; bus.tail_sent = 1'b0; bus.credit_in = 1'b0;
      rst = 1'b1;

      // Reset values
      step('0, 0, 0, 0, 1);
      step('0, 0, 0, 0, 1);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_credits", 32'(bus.credits), 32'd4);
      chk("rst_send_ok", 32'(bus.send_ok), 32'd0);

      // Rotation after a single-flit packet
      step(5'b10010, 0, 0, 0, 0);
      chk("first_grant", 32'(bus.gnt), 32'b00010);
      step(5'b10010, 1, 1, 0, 0);
      chk("idle_gap", 32'(bus.gnt), 32'd0);
      step(5'b10010, 0, 0, 1, 0);
      chk("rotated_grant", 32'(bus.gnt), 32'b10000);
      step(5'b00000, 0, 0, 0, 0);

      // All requesting, one tail flit per packet with credit returned alongside
      for (int i = 0; i < 12; i++) begin
         step(5'b11111, m_lock, m_lock, m_lock, 0);
         if (bus.gnt != '0) order.push_back(int'(bus.gnt_idx));
      end
      chk("order_len", 32'(order.size() >= 6), 32'd1);
      for (int i = 0; i < 6; i++)
         chk("order", (i < order.size()) ? 32'(order[i]) : 32'hffff_ffff, 32'(i % N));

      // Credit exhaustion and recovery on input 1
      step(5'b00010, 0, 0, 0, 0);
      chk("lock1_idx", 32'(bus.gnt_idx), 32'd1);
      for (int i = 0; i < 4; i++) step(5'b00010, 1, 0, 0, 0);
      chk("drained", 32'(bus.credits), 32'd0);
      chk("drained_ok", 32'(bus.send_ok), 32'd0);
      step(5'b00010, 1, 1, 0, 0);
      chk("blocked_tail_kept", 32'(bus.gnt), 32'b00010);
      step(5'b00010, 0, 0, 1, 0);
      chk("one_credit", 32'(bus.credits), 32'd1);
      step(5'b00010, 1, 0, 1, 0);
      chk("send_and_return", 32'(bus.credits), 32'd1);
      step(5'b00010, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(5'b00000, 0, 0, 1, 0);
      chk("refilled_saturate", 32'(bus.credits), 32'd4);

      // Abort by dropping the request, then reset while locked
      step(5'b01000, 0, 0, 0, 0);
      chk("lock3", 32'(bus.gnt), 32'b01000);
      step(5'b01000, 1, 0, 0, 0);
      step(5'b10001, 0, 0, 0, 0);
      chk("abort_idle", 32'(bus.gnt), 32'd0);
      step(5'b10001, 0, 0, 0, 0);
      chk("scan_from_4", 32'(bus.gnt_idx), 32'd4);
      step(5'b10001, 1, 0, 0, 0);
      step(5'b10001, 0, 0, 0, 1);
      chk("rst_locked_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_locked_cred", 32'(bus.credits), 32'd4);

      // Watchdog: 16 stalled cycles, then 15 stalled cycles ending with a credit return
      step(5'b00001, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(5'b00001, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(5'b00001, 0, 0, 0, 0);
`ifdef ARB_STALL_WDOG_EN
      chk("wdog_set", 32'(bus.stall_err), 32'd1);
`else
      chk("wdog_set", 32'(bus.stall_err), 32'd0);
`endif
      for (int i = 0; i < 4; i++) step(5'b00001, 0, 0, 1, 0);
`ifdef ARB_STALL_WDOG_EN
      chk("wdog_sticky", 32'(bus.stall_err), 32'd1);
`else
      chk("wdog_sticky", 32'(bus.stall_err), 32'd0);
`endif
      step(5'b00000, 0, 0, 0, 1);
      step(5'b00001, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(5'b00001, 1, 0, 0, 0);
      for (int i = 0; i < 14; i++) step(5'b00001, 0, 0, 0, 0);
      step(5'b00001, 0, 0, 1, 0);
      step(5'b00001, 0, 0, 0, 0);
      chk("wdog_short", 32'(bus.stall_err), 32'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         r = N'($urandom_range(0, (1 << N) - 1));
         if (m_lock && $urandom_range(0, 7) != 0) r[m_own] = 1'b1;
         f  = $urandom_range(0, 1) == 1;
         t  = $urandom_range(0, 3) == 0;
         c  = $urandom_range(0, 2) == 0;
         rs = $urandom_range(0, 149) == 0;
         step(r, f, t, c, rs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
